// File: rtl/apb_master_if.sv
// APB bus bundle between the master and a single slave.
// Latency: none, wires only.
// Backpressure: the slave stalls the master by holding i_PREADY low in ACCESS.
interface apb_master_if #(
    parameter int WIDTH = 8
);
    logic             o_PSEL1;
    logic             o_PENABLE;
    logic             o_PWRITE;
    logic [WIDTH-1:0] o_paddr;
    logic [WIDTH-1:0] o_pwdata;
    logic [WIDTH-1:0] i_prdata;
    logic             i_PREADY;

    modport master (
        output o_PSEL1, o_PENABLE, o_PWRITE, o_paddr, o_pwdata,
        input  i_prdata, i_PREADY
    );

    modport slave (
        input  o_PSEL1, o_PENABLE, o_PWRITE, o_paddr, o_pwdata,
        output i_prdata, i_PREADY
    );
endinterface

// File: rtl/apb_master.sv
// APB master: turns user request strobes into SETUP/ACCESS bus transfers with a wait-state timeout.
// Latency: 3 edges from an accepted i_transfer to o_done with a zero-wait slave; 2 cycles per back-to-back transfer.
// Backpressure: i_PREADY=0 stretches ACCESS up to TIMEOUT cycles, then the transfer aborts with o_error.
module apb_master #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             i_PCLK,
    input  logic             i_PRESETn,
    input  logic             i_transfer,
    input  logic             i_write,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_done,
    output logic             o_error,
    output logic             o_busy,
    apb_master_if.master     apb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Last wait-counter value that still allows one more stalled ACCESS cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    // Single state machine; every bus and user output is a register updated here.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            apb.o_PSEL1   <= 1'b0;
            apb.o_PENABLE <= 1'b0;
            apb.o_PWRITE  <= 1'b0;
            apb.o_paddr   <= '0;
            apb.o_pwdata  <= '0;
            o_rdata       <= '0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            o_done  <= 1'b0;
            o_error <= 1'b0;

            case (state)
                IDLE: begin
                    apb.o_PSEL1   <= 1'b0;
                    apb.o_PENABLE <= 1'b0;
                    o_busy        <= 1'b0;
                    if (i_transfer) begin
                        apb.o_paddr  <= i_addr;
                        apb.o_pwdata <= i_wdata;
                        apb.o_PWRITE <= i_write;
                        apb.o_PSEL1  <= 1'b1;
                        o_busy       <= 1'b1;
                        state        <= SETUP;
                    end
                end

                SETUP: begin
                    // Exactly one SETUP cycle; the wait counter starts fresh for ACCESS.
                    apb.o_PENABLE <= 1'b1;
                    wait_cnt      <= 8'd0;
                    state         <= ACCESS;
                end

                ACCESS: begin
                    if (apb.i_PREADY) begin
                        if (!apb.o_PWRITE) begin
                            o_rdata <= apb.i_prdata;
                        end
                        o_done        <= 1'b1;
                        apb.o_PENABLE <= 1'b0;
                        if (i_transfer) begin
                            // Back-to-back: PSEL1 stays high, go straight to the next SETUP.
                            apb.o_paddr  <= i_addr;
                            apb.o_pwdata <= i_wdata;
                            apb.o_PWRITE <= i_write;
                            state        <= SETUP;
                        end else begin
                            apb.o_PSEL1 <= 1'b0;
                            o_busy      <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Slave never answered: abort, leave o_rdata alone, ignore any new request.
                        o_done        <= 1'b1;
                        o_error       <= 1'b1;
                        apb.o_PSEL1   <= 1'b0;
                        apb.o_PENABLE <= 1'b0;
                        o_busy        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    apb.o_PSEL1   <= 1'b0;
                    apb.o_PENABLE <= 1'b0;
                    o_busy        <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: memory slave with programmable wait states plus a scoreboard of expected completions.
// Latency: checks 3+waits edges per single transfer and 2 cycles per back-to-back transfer.
// Backpressure: exercises wait states, timeout abort and reset in the middle of ACCESS.
module tb_apb_master;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst_n;
    logic             i_transfer;
    logic             i_write;
    logic [WIDTH-1:0] i_addr;
    logic [WIDTH-1:0] i_wdata;
    logic [WIDTH-1:0] o_rdata;
    logic             o_done;
    logic             o_error;
    logic             o_busy;

    apb_master_if #(.WIDTH(WIDTH)) apb ();

    apb_master #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_PCLK     (clk),
        .i_PRESETn  (rst_n),
        .i_transfer (i_transfer),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_busy     (o_busy),
        .apb        (apb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave: answers after slv_wait stalled ACCESS cycles, cleared by reset.
    logic [WIDTH-1:0] slv_mem [0:255];
    logic [7:0]       slv_cnt;
    int               slv_wait;

    assign apb.i_PREADY = apb.o_PSEL1 && apb.o_PENABLE && (int'(slv_cnt) >= slv_wait);
    assign apb.i_prdata = slv_mem[apb.o_paddr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= '0;
            slv_cnt <= 8'd0;
        end else if (apb.o_PSEL1 && apb.o_PENABLE) begin
            if (apb.i_PREADY) begin
                slv_cnt <= 8'd0;
                if (apb.o_PWRITE) slv_mem[apb.o_paddr] <= apb.o_pwdata;
            end else if (slv_cnt != 8'hFF) begin
                slv_cnt <= slv_cnt + 8'd1;
            end
        end
    end

    // Scoreboard entry: expected error flag and o_rdata at completion.
    typedef struct {
        logic             err;
        logic [WIDTH-1:0] rdata;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] ref_mem [0:255];
    logic [WIDTH-1:0] ref_rdata;
    int               checks;
    int               errors;
    logic             prev_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict the outcome of a request at the moment it is issued.
    task automatic push_exp(input logic wr, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                            input logic err);
        exp_t e;
        e.err = err;
        if (!err) begin
            if (wr) ref_mem[a] = d;
            else    ref_rdata = ref_mem[a];
        end
        e.rdata = ref_rdata;
        sb_q.push_back(e);
    endtask

    // Completion monitor: pops the scoreboard on every o_done pulse.
    always @(negedge clk) begin
        if (o_done) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_error", {31'd0, o_error}, {31'd0, e.err});
                check("done_rdata", {24'd0, o_rdata}, {24'd0, e.rdata});
            end
        end
        prev_done <= o_done;
    end

    // One isolated transfer; checks latency, PENABLE length and address stability.
    task automatic do_xfer(input logic wr, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                           input int exp_lat, input int exp_en, input logic err);
        int   lat;
        int   en;
        logic stable;
        @(negedge clk);
        push_exp(wr, a, d, err);
        i_transfer = 1'b1;
        i_write    = wr;
        i_addr     = a;
        i_wdata    = d;
        @(posedge clk);
        lat = 1;
        en  = 0;
        stable = 1'b1;
        @(negedge clk);
        i_transfer = 1'b0;
        i_addr     = ~a;
        i_wdata    = ~d;
        check("setup_pwrite", {31'd0, apb.o_PWRITE}, {31'd0, wr});
        check("setup_busy", {31'd0, o_busy}, 32'd1);
        if (wr) check("setup_pwdata", {24'd0, apb.o_pwdata}, {24'd0, d});
        while (!o_done && lat < 64) begin
            if (apb.o_PENABLE) begin
                en++;
                if (apb.o_paddr !== a || apb.o_PSEL1 !== 1'b1) stable = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("xfer_latency", lat, exp_lat);
        check("penable_cycles", en, exp_en);
        check("addr_stable", {31'd0, stable}, 32'd1);
        @(negedge clk);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
    endtask

    // Eight back-to-back transfers to addr 0..7 with i_transfer held high.
    task automatic b2b(input logic wr);
        int   gap;
        logic psel_low;
        psel_low = 1'b0;
        @(negedge clk);
        i_transfer = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_write = wr;
            i_addr  = 8'(i);
            i_wdata = 8'(i + 1);
            push_exp(wr, 8'(i), 8'(i + 1), 1'b0);
            gap = 0;
            do begin
                @(posedge clk);
                @(negedge clk);
                gap++;
                if (i > 0 && !apb.o_PSEL1) psel_low = 1'b1;
                if (gap == 1 && i > 0)
                    check("b2b_penable_high", {31'd0, apb.o_PENABLE}, 32'd1);
            end while (!(apb.o_PSEL1 && !apb.o_PENABLE && apb.o_paddr == 8'(i)) && gap < 10);
            check("b2b_gap", gap, (i == 0) ? 1 : 2);
        end
        i_transfer = 1'b0;
        check("b2b_psel_held", {31'd0, psel_low}, 32'd0);
        gap = 0;
        while (o_busy && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_drain", gap, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        prev_done = 1'b0;
        ref_rdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        slv_wait   = 0;
        rst_n      = 1'b0;
        i_transfer = 1'b0;
        i_write    = 1'b0;
        i_addr     = '0;
        i_wdata    = '0;

        #12;
        check("rst_psel", {31'd0, apb.o_PSEL1}, 32'd0);
        check("rst_penable", {31'd0, apb.o_PENABLE}, 32'd0);
        check("rst_pwrite", {31'd0, apb.o_PWRITE}, 32'd0);
        check("rst_paddr", {24'd0, apb.o_paddr}, 32'd0);
        check("rst_pwdata", {24'd0, apb.o_pwdata}, 32'd0);
        check("rst_rdata", {24'd0, o_rdata}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_error", {31'd0, o_error}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back through the memory slave.
        do_xfer(1'b1, 8'd3, 8'hA5, 3, 1, 1'b0);
        do_xfer(1'b0, 8'd3, 8'h00, 3, 1, 1'b0);

        // Back-to-back writes then reads.
        b2b(1'b1);
        b2b(1'b0);

        // Four wait states.
        slv_wait = 4;
        do_xfer(1'b0, 8'd3, 8'h00, 7, 5, 1'b0);

        // Slave never ready: abort after TIMEOUT ACCESS cycles.
        slv_wait = 200;
        do_xfer(1'b1, 8'd5, 8'h3C, 2 + TIMEOUT, TIMEOUT, 1'b1);
        slv_wait = 0;
        do_xfer(1'b0, 8'd5, 8'h00, 3, 1, 1'b0);

        // Reset in the middle of a stalled read.
        do_xfer(1'b0, 8'd3, 8'h00, 3, 1, 1'b0);
        slv_wait = 5;
        @(negedge clk);
        i_transfer = 1'b1;
        i_write    = 1'b0;
        i_addr     = 8'd3;
        @(posedge clk);
        @(negedge clk);
        i_transfer = 1'b0;
        n = 0;
        while (!apb.o_PENABLE && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_in_access", {31'd0, apb.o_PENABLE}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_psel", {31'd0, apb.o_PSEL1}, 32'd0);
        check("arst_penable", {31'd0, apb.o_PENABLE}, 32'd0);
        check("arst_rdata", {24'd0, o_rdata}, 32'd0);
        check("arst_paddr", {24'd0, apb.o_paddr}, 32'd0);
        check("arst_busy", {31'd0, o_busy}, 32'd0);
        check("arst_done", {31'd0, o_done}, 32'd0);
        sb_q.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_rdata = '0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        slv_wait = 0;
        do_xfer(1'b0, 8'd3, 8'h00, 3, 1, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, address/data width.
REQ-002 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles before abort (legal range 2..255).
REQ-003 SHALL have port i_PCLK, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port i_PRESETn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_transfer, input, 1: user request strobe.
REQ-006 SHALL have port i_write, input, 1: request direction, 1=write, 0=read.
REQ-007 SHALL have port i_addr, input, WIDTH: request address.
REQ-008 SHALL have port i_wdata, input, WIDTH: request write data.
REQ-009 SHALL have port o_rdata, output, WIDTH: read data of last completed read.
REQ-010 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port o_error, output, 1: one-cycle timeout pulse, coincident with o_done.
REQ-012 SHALL have port o_busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have ports o_PSEL1, o_PENABLE, o_PWRITE (1 bit each), o_paddr and o_pwdata (WIDTH each), outputs, and i_prdata (WIDTH) and i_PREADY (1), inputs: APB bus to the slave.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS. All bus and user outputs SHALL be registered.
REQ-015 IDLE: PSEL1=0 and PENABLE=0. When i_transfer=1 at the edge, the FSM SHALL latch i_addr, i_wdata and i_write into o_paddr, o_pwdata and o_PWRITE, then go to SETUP.
REQ-016 SETUP: PSEL1=1 and PENABLE=0 for exactly one cycle, then unconditionally ACCESS.
REQ-017 ACCESS: PSEL1=1 and PENABLE=1. o_paddr, o_pwdata and o_PWRITE SHALL stay stable from SETUP through the end of ACCESS.
REQ-018 When i_PREADY=1 is sampled in ACCESS, the transfer completes. For a read, o_rdata <= i_prdata. o_done SHALL be 1 in the next cycle only.
REQ-019 On completion with i_transfer=1, the FSM SHALL latch the new request and go directly to SETUP (back-to-back). Otherwise it goes to IDLE.
REQ-020 i_transfer SHALL be ignored in SETUP, and in ACCESS cycles that do not complete.
REQ-021 Wait counter (8 bits): cleared on entry to ACCESS, incremented each ACCESS cycle with i_PREADY=0.
REQ-022 When the counter equals TIMEOUT-1 and i_PREADY=0, the FSM SHALL abort: o_done=1 and o_error=1 next cycle, o_rdata unchanged, go to IDLE regardless of i_transfer.
REQ-023 i_PREADY SHALL be ignored outside ACCESS.
REQ-024 o_rdata SHALL hold its value until the next successful read. Writes and aborts leave it unchanged.
REQ-025 Minimum transfer latency, i_transfer to o_done with zero-wait slave: 3 edges (IDLE->SETUP->ACCESS->done).
REQ-026 o_busy SHALL be 1 in SETUP and ACCESS, 0 in IDLE.

Reset
REQ-027 i_PRESETn=0 SHALL asynchronously force state IDLE and clear the counter.
REQ-028 Reset SHALL clear o_PSEL1, o_PENABLE, o_PWRITE, o_paddr, o_pwdata, o_rdata, o_done, o_error and o_busy to 0.
REQ-029 Reset asserted mid-transfer (SETUP or ACCESS) SHALL drop PSEL1/PENABLE immediately, without asserting o_done.
REQ-030 After deassertion, the first transfer SHALL be accepted on the first edge with i_transfer=1.

Verification
REQ-031 Write then read with the memory slave: write addr 3, data 8'hA5; then read addr 3 -> o_PWRITE 1 then 0, o_rdata=8'hA5, each o_done 3 edges after its i_transfer.
REQ-032 Back-to-back: hold i_transfer=1 with writes to addr 0..7 (data=addr+1) -> PSEL1 stays 1, PENABLE toggles 0/1, each transfer takes 2 cycles; reads then return 1..8.
REQ-033 Wait states: slave model holds i_PREADY=0 for 4 ACCESS cycles -> PENABLE high for 5 cycles, addr stable, o_done once, o_error=0.
REQ-034 Timeout: i_PREADY held 0 with TIMEOUT=16 -> abort after 16 ACCESS cycles, o_done=o_error=1 for one cycle, o_rdata unchanged, then IDLE.
REQ-035 Reset during ACCESS of a read -> all outputs 0 asynchronously, no o_done; the next read of addr 3 returns 8'h00 (slave also reset).
